// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI bridge initiator and target.
// Command byte layout, frame lengths, FSM state encoding.
package spi_bridge_pkg;

  localparam int CMD_A16      = 0;
  localparam int CMD_RW_B     = 1;
  localparam int CMD_SET_ADDR = 2;
  localparam int CMD_LEN_LSB  = 5;

  localparam logic [2:0] LEN_WR_ADDR = 3'd4;
  localparam logic [2:0] LEN_RD_ADDR = 3'd3;
  localparam logic [2:0] LEN_WR      = 3'd2;
  localparam logic [2:0] LEN_RD      = 3'd1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    SHIFT     = 3'd2,
    WAIT_DONE = 3'd3,
    READBACK  = 3'd4,
    RELEASE   = 3'd5
  } state_e;

  typedef struct packed {
    logic        rw_b;
    logic        set_addr;
    logic [16:0] addr;
    logic [7:0]  data;
  } req_t;

  function automatic logic [2:0] frame_len(
    input logic rw_b,
    input logic set_addr
  );
    logic [2:0] l;
    unique case ({set_addr, rw_b})
      2'b11:   l = LEN_RD_ADDR;
      2'b10:   l = LEN_WR_ADDR;
      2'b01:   l = LEN_RD;
      default: l = LEN_WR;
    endcase
    return l;
  endfunction

  function automatic logic [7:0] cmd_byte(input req_t r);
    logic [7:0] c;
    c = '0;
    // a16 only matters when an address is loaded
    c[CMD_A16]      = r.set_addr & r.addr[16];
    c[CMD_RW_B]     = r.rw_b;
    c[CMD_SET_ADDR] = r.set_addr;
    c[CMD_LEN_LSB +: 3] = frame_len(r.rw_b, r.set_addr);
    return c;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode 0 byte engine: SCLK divider, MSB-first shift, sample.
// Ports: start_i/tx_i load, sclk_o/mosi_o/miso_i, busy_o, done_o, rx_o.
module spi_byte_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] tx_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rx_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          ph_q, ph_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    rx_q, rx_d;
  logic          busy_q, busy_d;
  logic          sclk_q, sclk_d;
  logic          half_end;

  always_comb begin
    div_d  = div_q;
    ph_d   = ph_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    rx_d   = rx_q;
    busy_d = busy_q;
    sclk_d = sclk_q;
    half_end = busy_q &&
      (div_q == DW'(CLK_DIV - 1));
    done_o = half_end && ph_q &&
      (bit_q == 3'd7);
    if (busy_q) begin
      div_d = half_end ? '0 : div_q + 1'b1;
      if (half_end) begin
        if (!ph_q) begin
          sclk_d = 1'b1;
          ph_d   = 1'b1;
          rx_d   = {rx_q[6:0], miso_i};
        end else begin
          sclk_d = 1'b0;
          ph_d   = 1'b0;
          if (bit_q == 3'd7) begin
            busy_d = 1'b0;
            sh_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {sh_q[6:0], 1'b0};
          end
        end
      end
    end
    // reload on the final falling edge keeps bytes gapless
    if (start_i && (!busy_q || done_o)) begin
      busy_d = 1'b1;
      sh_d   = tx_i;
      bit_d  = '0;
      ph_d   = 1'b0;
      div_d  = '0;
      sclk_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      ph_q   <= 1'b0;
      bit_q  <= '0;
      sh_q   <= '0;
      rx_q   <= '0;
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      ph_q   <= ph_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      rx_q   <= rx_d;
      busy_q <= busy_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = sh_q[7];
  assign busy_o = busy_q;
  assign rx_o   = rx_q;

endmodule

// File: rtl/spi_bridge_master.sv
// SPI bridge initiator: frames one bus request, runs pending/done.
// Ports: req_* in, resp_* out, spi_* pins, state for debug.
module spi_bridge_master
  import spi_bridge_pkg::*;
#(
  parameter int CLK_DIV        = 2,
  parameter int SETUP_CYCLES   = 4,
  parameter int RELEASE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw_b,
  input  logic        req_set_addr,
  input  logic [16:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  output logic        resp_timeout,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_pending,
  input  logic        spi_done,
  output logic [2:0]  state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES +
    SETUP_CYCLES + RELEASE_CYCLES + CLK_DIV + 1) + 1;

  state_e        st_q, st_d;
  req_t          req_q, req_d;
  logic [2:0]    len_q, len_d;
  logic [1:0]    idx_q, idx_d;
  logic          tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic          cs_n_q, cs_n_d;
  logic          pend_q, pend_d;
  logic          rv_q, rv_d;
  logic          rto_q, rto_d;
  logic [7:0]    rdat_q, rdat_d;
  logic          rdy_en_q;
  logic          miso_s1_q, miso_s2_q;
  logic          done_s1_q, done_s2_q;

  logic       sh_start;
  logic [7:0] sh_tx;
  logic       sh_busy;
  logic       sh_done;
  logic [7:0] sh_rx;

  function automatic logic [7:0] frame_byte(
    input req_t       r,
    input logic [1:0] idx
  );
    logic [7:0] b;
    b = cmd_byte(r);
    unique case (1'b1)
      r.set_addr && idx == 2'd1: b = r.addr[15:8];
      r.set_addr && idx == 2'd2: b = r.addr[7:0];
      r.set_addr && idx == 2'd3: b = r.data;
      !r.set_addr && idx == 2'd1: b = r.data;
      default: ;
    endcase
    return b;
  endfunction

  spi_byte_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clk_i  (sys_clk),
    .rst_ni (reset_n),
    .start_i(sh_start),
    .tx_i   (sh_tx),
    .miso_i (miso_s2_q),
    .sclk_o (spi_sclk),
    .mosi_o (spi_mosi),
    .busy_o (sh_busy),
    .done_o (sh_done),
    .rx_o   (sh_rx)
  );

  // ready is held off during the resp_valid cycle
  assign req_ready = (st_q == IDLE) &&
    rdy_en_q && !rv_q;

  always_comb begin
    st_d     = st_q;
    req_d    = req_q;
    len_d    = len_q;
    idx_d    = idx_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    cs_n_d   = cs_n_q;
    pend_d   = pend_q;
    rdat_d   = rdat_q;
    rv_d     = 1'b0;
    rto_d    = 1'b0;
    sh_start = 1'b0;
    sh_tx    = '0;
    unique case (st_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d = '{rw_b:     req_rw_b,
                    set_addr: req_set_addr,
                    addr:     req_addr,
                    data:     req_data};
          len_d  = frame_len(req_rw_b, req_set_addr);
          idx_d  = '0;
          cnt_d  = '0;
          to_d   = 1'b0;
          pend_d = 1'b1;
          st_d   = ARM;
        end
      end
      ARM: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SETUP_CYCLES - 1) &&
            !sh_busy) begin
          sh_start = 1'b1;
          sh_tx    = frame_byte(req_q, 2'd0);
          cs_n_d   = 1'b0;
          tail_d   = 1'b0;
          st_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (tail_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(CLK_DIV - 1)) begin
            cs_n_d = 1'b1;
            cnt_d  = '0;
            st_d   = WAIT_DONE;
          end
        end else if (sh_done) begin
          if ({1'b0, idx_q} == len_q - 3'd1) begin
            tail_d = 1'b1;
            cnt_d  = '0;
          end else begin
            idx_d    = idx_q + 2'd1;
            sh_start = 1'b1;
            sh_tx    = frame_byte(req_q,
                         idx_q + 2'd1);
          end
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        // done is trusted only after the setup gap
        if (done_s2_q &&
            cnt_q >= CW'(SETUP_CYCLES)) begin
          cnt_d = '0;
          if (req_q.rw_b) begin
            sh_start = 1'b1;
            cs_n_d   = 1'b0;
            tail_d   = 1'b0;
            st_d     = READBACK;
          end else begin
            pend_d = 1'b0;
            st_d   = RELEASE;
          end
        end else if (cnt_q ==
                     CW'(TIMEOUT_CYCLES - 1)) begin
          to_d   = 1'b1;
          cnt_d  = '0;
          pend_d = 1'b0;
          st_d   = RELEASE;
        end
      end
      READBACK: begin
        if (tail_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(CLK_DIV - 1)) begin
            cs_n_d = 1'b1;
            pend_d = 1'b0;
            cnt_d  = '0;
            st_d   = RELEASE;
          end
        end else if (sh_done) begin
          rdat_d = sh_rx;
          tail_d = 1'b1;
          cnt_d  = '0;
        end
      end
      RELEASE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(RELEASE_CYCLES - 1)) begin
          rv_d  = 1'b1;
          rto_d = to_q;
          cnt_d = '0;
          st_d  = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= IDLE;
      req_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      tail_q    <= 1'b0;
      cnt_q     <= '0;
      to_q      <= 1'b0;
      cs_n_q    <= 1'b1;
      pend_q    <= 1'b0;
      rv_q      <= 1'b0;
      rto_q     <= 1'b0;
      rdat_q    <= '0;
      rdy_en_q  <= 1'b0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
      done_s1_q <= 1'b0;
      done_s2_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      req_q     <= req_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      cs_n_q    <= cs_n_d;
      pend_q    <= pend_d;
      rv_q      <= rv_d;
      rto_q     <= rto_d;
      rdat_q    <= rdat_d;
      rdy_en_q  <= 1'b1;
      miso_s1_q <= spi_miso;
      miso_s2_q <= miso_s1_q;
      done_s1_q <= spi_done;
      done_s2_q <= done_s1_q;
    end
  end

  assign resp_valid   = rv_q;
  assign resp_data    = rdat_q;
  assign resp_timeout = rto_q;
  assign spi_cs_n     = cs_n_q;
  assign spi_pending  = pend_q;
  assign state        = st_q;

endmodule

// File: tb/tb_spi_bridge_master.sv
// Self-checking bench for spi_bridge_master.
// Directed table, reset corner case and random requests vs a model.
module tb_spi_bridge_master;

  localparam int CLK_DIV = 2;
  localparam int SETUP   = 4;
  localparam int REL     = 4;
  localparam int TMO     = 16;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw_b = 1'b0;
  logic        req_set_addr = 1'b0;
  logic [16:0] req_addr = '0;
  logic [7:0]  req_data = '0;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic        resp_timeout;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic        spi_pending;
  logic        spi_done = 1'b0;
  logic [2:0]  state;

  always #5 sys_clk = ~sys_clk;

  spi_bridge_master #(
    .CLK_DIV(CLK_DIV),
    .SETUP_CYCLES(SETUP),
    .RELEASE_CYCLES(REL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sys_clk(sys_clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rw_b(req_rw_b),
    .req_set_addr(req_set_addr),
    .req_addr(req_addr),
    .req_data(req_data),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_timeout(resp_timeout),
    .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_pending(spi_pending),
    .spi_done(spi_done),
    .state(state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // pin monitor
  logic [7:0] mon_bytes[$];
  int win_bits[$];
  int t_csf[$], t_r1[$], t_lf[$], t_csr[$];
  int t_pr, t_pf, t_rv, n_rv, viol, bits, last_fall;
  logic [7:0] cur;

  initial begin
    logic p_sclk, p_cs, p_mosi, p_pend;
    p_sclk = 0; p_cs = 1; p_mosi = 0; p_pend = 0;
    bits = 0; viol = 0; n_rv = 0; last_fall = 0;
    cur = '0;
    forever begin
      @(negedge sys_clk);
      if (p_cs && !spi_cs_n) begin
        bits = 0;
        t_csf.push_back(cyc);
      end
      if (!spi_cs_n && spi_sclk && !p_sclk) begin
        if (bits == 0) t_r1.push_back(cyc);
        cur = {cur[6:0], spi_mosi};
        bits++;
        if (bits % 8 == 0) mon_bytes.push_back(cur);
      end
      if (!spi_sclk && p_sclk) last_fall = cyc;
      if (spi_sclk && p_sclk && spi_mosi !== p_mosi)
        viol++;
      if (!p_cs && spi_cs_n) begin
        win_bits.push_back(bits);
        t_csr.push_back(cyc);
        t_lf.push_back(last_fall);
      end
      if (spi_pending && !p_pend) t_pr = cyc;
      if (!spi_pending && p_pend) t_pf = cyc;
      if (resp_valid === 1'b1) begin
        n_rv++;
        t_rv = cyc;
      end
      p_sclk = spi_sclk;
      p_cs   = spi_cs_n;
      p_mosi = spi_mosi;
      p_pend = spi_pending;
    end
  end

  // target model: 0 never done, 1 done 10 cycles after CS, 2 done early
  int tgt_mode = 1;
  logic [7:0] tgt_rb = '0;

  initial begin
    int tw, dcnt, rbi;
    logic tp_cs, tp_sclk;
    tw = 0; dcnt = -1; rbi = -1;
    tp_cs = 1; tp_sclk = 0;
    forever begin
      @(negedge sys_clk);
      if (!reset_n || !spi_pending) begin
        spi_done = 0;
        tw = 0;
        dcnt = -1;
        rbi = -1;
      end else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin
            spi_done = 1;
            spi_miso = tgt_rb[7];
            rbi = 6;
          end
        end
        if (!tp_cs && spi_cs_n) begin
          tw++;
          if (tw == 1 && tgt_mode == 1) dcnt = 10;
        end
        if (tgt_mode == 2) spi_done = 1;
        if (tw == 1 && !spi_cs_n && spi_sclk &&
            !tp_sclk && rbi >= 0) begin
          spi_miso = tgt_rb[rbi];
          rbi--;
        end
      end
      tp_cs = spi_cs_n;
      tp_sclk = spi_sclk;
    end
  end

  logic [7:0] model_rdata = '0;

  task automatic clear_mon();
    mon_bytes.delete();
    win_bits.delete();
    t_csf.delete();
    t_r1.delete();
    t_lf.delete();
    t_csr.delete();
    n_rv = 0;
  endtask

  task automatic offer(input logic rw, input logic sa,
                       input logic [16:0] ad,
                       input logic [7:0] dt,
                       input string nm);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    chk({nm, " ready"}, req_ready, 1);
    req_valid = 1;
    req_rw_b = rw;
    req_set_addr = sa;
    req_addr = ad;
    req_data = dt;
    @(posedge sys_clk);
    #1;
    req_valid = 0;
    req_rw_b = 1'($urandom);
    req_set_addr = 1'($urandom);
    req_addr = 17'($urandom);
    req_data = 8'($urandom);
  endtask

  task automatic run_txn(input logic rw, input logic sa,
                         input logic [16:0] ad,
                         input logic [7:0] dt,
                         input logic [7:0] rb,
                         input int mode,
                         input string nm,
                         output logic [7:0] first);
    logic [7:0] exp[$];
    int len, k, nwin;
    logic [7:0] cmd;
    logic exp_to;
    len = sa ? (rw ? 3 : 4) : (rw ? 1 : 2);
    cmd = 8'(len * 32 + sa * 4 + rw * 2 + (sa & ad[16]));
    exp.push_back(cmd);
    if (sa) begin
      exp.push_back(ad[15:8]);
      exp.push_back(ad[7:0]);
    end
    if (!rw) exp.push_back(dt);
    exp_to = (mode == 0);
    if (rw && !exp_to) model_rdata = rb;
    nwin = (rw && !exp_to) ? 2 : 1;
    tgt_mode = mode;
    tgt_rb = rb;
    clear_mon();
    offer(rw, sa, ad, dt, nm);
    k = 0;
    while (resp_valid !== 1'b1 && k < 1500) begin
      tick();
      k++;
    end
    chk({nm, " resp seen"}, resp_valid, 1);
    chk({nm, " timeout"}, resp_timeout, exp_to);
    chk({nm, " rdata"}, resp_data, model_rdata);
    chk({nm, " rdy@rv"}, req_ready, 0);
    tick();
    chk({nm, " rv pulse"}, resp_valid, 0);
    chk({nm, " rdy after"}, req_ready, 1);
    chk({nm, " rv count"}, n_rv, 1);
    chk({nm, " windows"}, win_bits.size(), nwin);
    first = (mon_bytes.size() > 0) ? mon_bytes[0] : 8'hxx;
    if (win_bits.size() > 0) begin
      chk({nm, " frame bits"}, win_bits[0], len * 8);
      for (int i = 0; i < len; i++)
        if (i < mon_bytes.size())
          chk($sformatf("%s byte%0d", nm, i),
              mon_bytes[i], exp[i]);
      chk({nm, " setup"}, t_csf[0] - t_pr, SETUP);
      chk({nm, " cs lead"}, t_r1[0] - t_csf[0], CLK_DIV);
      chk({nm, " cs lag"}, t_csr[0] - t_lf[0], CLK_DIV);
      if (exp_to)
        chk({nm, " tmo len"}, t_pf - t_csr[0], TMO);
      if (mode == 2)
        chk({nm, " early ign"},
            32'(t_pf - t_csr[0] > SETUP), 1);
    end
    if (nwin == 2 && win_bits.size() > 1) begin
      chk({nm, " rb bits"}, win_bits[1], 8);
      if (mon_bytes.size() > len)
        chk({nm, " rb mosi"}, mon_bytes[len], 8'h00);
    end
    chk({nm, " release"}, t_rv - t_pf, REL);
  endtask

  typedef struct {
    logic        rw;
    logic        sa;
    logic [16:0] ad;
    logic [7:0]  dt;
    logic [7:0]  rb;
    int          mode;
    logic [7:0]  exp_cmd;
    logic [7:0]  exp_rd;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    logic [7:0] fb;
    int k;
    tbl[0] = '{0, 1, 17'h1_8000, 8'hA5, 8'h00, 1, 8'h85, 8'h00};
    tbl[1] = '{1, 1, 17'h0_E810, 8'h00, 8'h3C, 1, 8'h66, 8'h3C};
    tbl[2] = '{0, 0, 17'h0_0000, 8'h11, 8'h00, 1, 8'h40, 8'h3C};
    tbl[3] = '{1, 0, 17'h0_0000, 8'h00, 8'h5A, 1, 8'h22, 8'h5A};
    tbl[4] = '{1, 1, 17'h1_0001, 8'h00, 8'hFF, 0, 8'h67, 8'h5A};
    tbl[5] = '{0, 0, 17'h0_1234, 8'hC3, 8'h00, 2, 8'h40, 8'h5A};
    tbl[6] = '{0, 0, 17'h1_FFFF, 8'h7E, 8'h00, 1, 8'h40, 8'h5A};

    #2 reset_n = 0;
    #1;
    chk("rst ready", req_ready, 0);
    chk("rst rv", resp_valid, 0);
    chk("rst rdata", resp_data, 0);
    chk("rst rto", resp_timeout, 0);
    chk("rst sclk", spi_sclk, 0);
    chk("rst cs", spi_cs_n, 1);
    chk("rst mosi", spi_mosi, 0);
    chk("rst pend", spi_pending, 0);
    chk("rst state", state, 0);
    repeat (3) tick();
    reset_n = 1;
    tick();
    chk("ready after rst", req_ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].rw, tbl[i].sa, tbl[i].ad,
              tbl[i].dt, tbl[i].rb, tbl[i].mode,
              $sformatf("vec%0d", i), fb);
      chk($sformatf("vec%0d cmd", i), fb, tbl[i].exp_cmd);
      chk($sformatf("vec%0d rd", i), resp_data,
          tbl[i].exp_rd);
    end

    // reset during the third byte of an addressed write
    tgt_mode = 1;
    clear_mon();
    offer(0, 1, 17'h0_4321, 8'h99, "rstmid");
    k = 0;
    while (bits < 18 && k < 400) begin
      tick();
      k++;
    end
    chk("rstmid reach", 32'(bits >= 18), 1);
    reset_n = 0;
    #1;
    chk("rstmid cs", spi_cs_n, 1);
    chk("rstmid pend", spi_pending, 0);
    chk("rstmid sclk", spi_sclk, 0);
    chk("rstmid state", state, 0);
    repeat (4) tick();
    chk("rstmid no rv", n_rv, 0);
    reset_n = 1;
    model_rdata = '0;
    tick();
    chk("rstmid rdata", resp_data, 0);
    run_txn(1, 1, 17'h1_0A0B, 8'h00, 8'hC6, 1,
            "after rst", fb);

    for (int i = 0; i < 24; i++) begin
      logic rw, sa;
      int md;
      rw = 1'($urandom);
      sa = 1'($urandom);
      md = ($urandom_range(0, 9) < 8) ? 1 : 0;
      run_txn(rw, sa, 17'($urandom), 8'($urandom),
              8'($urandom), md,
              $sformatf("rnd%0d", i), fb);
    end

    chk("mosi stable hi", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
